// File: rtl/stud_ds_demodulator_pkg.sv
// Shared constants for the delta-sigma demodulator: CIC geometry, OSR codes
// and the OSR-code to log2(R) lookup.
package stud_ds_demodulator_pkg;

    localparam int CIC_ORDER = 3;
    localparam int ACC_W     = 26;

    localparam logic [1:0] OSR_32  = 2'b00;
    localparam logic [1:0] OSR_64  = 2'b01;
    localparam logic [1:0] OSR_128 = 2'b10;
    localparam logic [1:0] OSR_256 = 2'b11;

    function automatic logic [3:0] osrLog2(input logic [1:0] osr);
        logic [3:0] k;
        case (osr)
            OSR_32:  k = 4'd5;
            OSR_64:  k = 4'd6;
            OSR_128: k = 4'd7;
            default: k = 4'd8;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/stud_ds_demodulator_cic.sv
// Third-order CIC decimator for a +/-1 bitstream. It emits a one-cycle strobe
// per window once the comb chain has seen two full windows since reset/clear.
module stud_ds_demodulator_cic
    import stud_ds_demodulator_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    ds_i,
    input  logic [3:0]              k_i,
    output logic signed [ACC_W-1:0] y_o,
    output logic                    yStb_o
);

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] integ1_q, integ2_q, integ3_q;
    logic signed [ACC_W-1:0] integ1_d, integ2_d, integ3_d;
    logic signed [ACC_W-1:0] dly1_q, dly2_q, dly3_q;
    logic signed [ACC_W-1:0] comb1, comb2, comb3;
    logic signed [ACC_W-1:0] y_q;
    logic [7:0]              cnt_q, cnt_d, cntMax;
    logic [1:0]              warmCnt_q;
    logic                    yStb_q;
    logic                    tick;

    // Integrators are chained combinationally so the tick sample includes this cycle's bit.
    always_comb begin
        x        = {{(ACC_W-1){~ds_i}}, 1'b1};
        integ1_d = integ1_q + x;
        integ2_d = integ2_q + integ1_d;
        integ3_d = integ3_q + integ2_d;
        comb1    = integ3_d - dly1_q;
        comb2    = comb1 - dly2_q;
        comb3    = comb2 - dly3_q;
        cntMax   = (8'd1 << k_i) - 8'd1;
        tick     = (cnt_q == cntMax);
        cnt_d    = tick ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            integ1_q  <= '0;
            integ2_q  <= '0;
            integ3_q  <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            warmCnt_q <= '0;
            yStb_q    <= 1'b0;
        end else begin
            integ1_q <= integ1_d;
            integ2_q <= integ2_d;
            integ3_q <= integ3_d;
            cnt_q    <= cnt_d;
            yStb_q   <= 1'b0;
            if (tick) begin
                dly1_q <= integ3_d;
                dly2_q <= comb1;
                dly3_q <= comb2;
                y_q    <= comb3;
                if (warmCnt_q == 2'd2) begin
                    yStb_q <= 1'b1;
                end else begin
                    warmCnt_q <= warmCnt_q + 2'd1;
                end
            end
        end
    end

    assign y_o    = y_q;
    assign yStb_o = yStb_q;

endmodule

// File: rtl/stud_ds_demodulator.sv
// Delta-sigma bitstream to PCM: OSR-change detection, scaling with saturation,
// and a single-entry valid/ready hold register with overrun reporting.
module stud_ds_demodulator
    import stud_ds_demodulator_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ds_i,
    input  logic [1:0]                    osr_i,
    output logic signed [AUDIO_WIDTH-1:0] audio_o,
    output logic                          audio_valid_o,
    input  logic                          audio_rdy_i,
    output logic                          overrun_o
);

    localparam logic signed [ACC_W-1:0] SAT_POS = ACC_W'(2**(AUDIO_WIDTH-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_NEG = ACC_W'(-(2**(AUDIO_WIDTH-1)));

    logic [1:0]                    osr_q;
    logic                          osrChange;
    logic [3:0]                    k;
    logic [4:0]                    shiftAmt;
    logic signed [ACC_W-1:0]       y;
    logic signed [ACC_W-1:0]       shifted;
    logic                          yStb;
    logic signed [AUDIO_WIDTH-1:0] scaled;
    logic signed [AUDIO_WIDTH-1:0] sample_q;
    logic                          sampleVld_q;
    logic signed [AUDIO_WIDTH-1:0] audio_q, audio_d;
    logic                          valid_q, valid_d;
    logic                          overrun_q, overrun_d;

    assign osrChange = (osr_i != osr_q);
    assign k         = osrLog2(osr_q);

    stud_ds_demodulator_cic u_cic (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (osrChange),
        .ds_i    (ds_i),
        .k_i     (k),
        .y_o     (y),
        .yStb_o  (yStb)
    );

    // Only +2^(W-1) can exceed the signed range; the negative clamp is a safety net.
    always_comb begin
        shiftAmt = 5'(k) * 5'd3 - 5'(AUDIO_WIDTH - 1);
        shifted  = y >>> shiftAmt;
        if (shifted > SAT_POS) begin
            scaled = SAT_POS[AUDIO_WIDTH-1:0];
        end else if (shifted < SAT_NEG) begin
            scaled = SAT_NEG[AUDIO_WIDTH-1:0];
        end else begin
            scaled = shifted[AUDIO_WIDTH-1:0];
        end
    end

    always_comb begin
        audio_d   = audio_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (sampleVld_q) begin
            audio_d   = sample_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !audio_rdy_i;
        end else if (valid_q && audio_rdy_i) begin
            valid_d = 1'b0;
        end
    end

    // The OSR copy tracks the input during reset so release never looks like a change.
    always_ff @(posedge clk_i) begin
        osr_q <= osr_i;
        if (rst_i) begin
            sample_q    <= '0;
            sampleVld_q <= 1'b0;
            audio_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sample_q    <= scaled;
            sampleVld_q <= yStb;
            audio_q     <= audio_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign audio_o       = audio_q;
    assign audio_valid_o = valid_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_stud_ds_demodulator.sv
// Directed bench for stud_ds_demodulator: hand-computed CIC results, latency,
// handshake, overrun, OSR change and mid-window reset.
module tb_stud_ds_demodulator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ds_i = 1'b0;
    logic [1:0]  osr_i = 2'b00;
    logic        audio_rdy_i = 1'b1;
    logic [15:0] audioO;
    logic        audioValidO;
    logic        overrunO;

    logic [3:0]  patBits = 4'b0001;
    int          patLen = 1;
    int          patIdx = 0;
    int          assertCount = 0;
    int          failCount = 0;
    int          pulses;

    stud_ds_demodulator #(.AUDIO_WIDTH(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ds_i          (ds_i),
        .osr_i         (osr_i),
        .audio_o       (audioO),
        .audio_valid_o (audioValidO),
        .audio_rdy_i   (audio_rdy_i),
        .overrun_o     (overrunO)
    );

    always #5 clk_i = ~clk_i;

    // Drives one pattern bit per cycle and samples 1 time unit after each rising edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            ds_i   = patBits[patIdx];
            patIdx = (patIdx + 1) % patLen;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [15:0] expAudio,
                               input logic expOverrun);
        checkEq({tag, "/valid"}, 32'(audioValidO), 32'(expValid));
        checkEq({tag, "/audio"}, 32'(audioO), 32'(expAudio));
        checkEq({tag, "/overrun"}, 32'(overrunO), 32'(expOverrun));
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(2);
        rst_i  = 1'b0;
        patIdx = 0;
    endtask

    task automatic setPattern(input logic [3:0] bits, input int len);
        patBits = bits;
        patLen  = len;
        patIdx  = 0;
    endtask

    initial begin
        // Constant 1 at R=32: first sample at edge 98, then every 32 cycles.
        setPattern(4'b0001, 1);
        osr_i       = 2'b00;
        audio_rdy_i = 1'b1;
        rst_i       = 1'b1;
        applyStimulus(3);
        checkOutput("reset", 1'b0, 16'h0000, 1'b0);
        rst_i  = 1'b0;
        patIdx = 0;
        applyStimulus(97);
        checkOutput("c1_e97", 1'b0, 16'h0000, 1'b0);
        applyStimulus(1);
        checkOutput("c1_e98", 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1);
        checkEq("c1_e99_consumed", 32'(audioValidO), 32'd0);
        applyStimulus(30);
        checkEq("c1_e129", 32'(audioValidO), 32'd0);
        applyStimulus(1);
        checkOutput("c1_e130", 1'b1, 16'h7FFF, 1'b0);

        // Backpressure: hold, overrun pulses, then ready coinciding with a load.
        audio_rdy_i = 1'b0;
        applyStimulus(31);
        checkOutput("bp_e161", 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1);
        checkOutput("bp_e162", 1'b1, 16'h7FFF, 1'b1);
        applyStimulus(1);
        checkEq("bp_e163_pulse_end", 32'(overrunO), 32'd0);
        pulses = 0;
        for (int i = 0; i < 66; i++) begin
            applyStimulus(1);
            if (overrunO) pulses++;
        end
        checkEq("bp_pulse_count", 32'(pulses), 32'd2);
        applyStimulus(28);
        checkOutput("bp_e257", 1'b1, 16'h7FFF, 1'b0);
        audio_rdy_i = 1'b1;
        applyStimulus(1);
        checkOutput("bp_e258_rdy_load", 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1);
        checkEq("bp_e259_consumed", 32'(audioValidO), 32'd0);

        // Constant 0 at R=32 gives exactly -32768.
        setPattern(4'b0000, 1);
        doReset();
        applyStimulus(98);
        checkOutput("c0_e98", 1'b1, 16'h8000, 1'b0);
        applyStimulus(32);
        checkOutput("c0_e130", 1'b1, 16'h8000, 1'b0);

        // Alternating 1,0 at R=64 averages to zero.
        setPattern(4'b0001, 2);
        osr_i = 2'b01;
        doReset();
        applyStimulus(193);
        checkEq("alt_e193", 32'(audioValidO), 32'd0);
        applyStimulus(1);
        checkOutput("alt_e194", 1'b1, 16'h0000, 1'b0);
        applyStimulus(64);
        checkOutput("alt_e258", 1'b1, 16'h0000, 1'b0);

        // 1,1,1,0 at R=32 has mean 1/2: 32768/2.
        setPattern(4'b0111, 4);
        osr_i = 2'b00;
        doReset();
        applyStimulus(98);
        checkOutput("p1110_e98", 1'b1, 16'h4000, 1'b0);

        // Constant 1 at R=256: 2^24 >>> 9 saturates.
        setPattern(4'b0001, 1);
        osr_i = 2'b11;
        doReset();
        applyStimulus(769);
        checkEq("r256_e769", 32'(audioValidO), 32'd0);
        applyStimulus(1);
        checkOutput("r256_e770", 1'b1, 16'h7FFF, 1'b0);

        // OSR change mid-window with a pending sample, then a mid-window reset.
        osr_i       = 2'b00;
        audio_rdy_i = 1'b0;
        doReset();
        applyStimulus(98);
        checkOutput("osr_e98", 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(12);
        osr_i = 2'b10;
        applyStimulus(1);
        checkOutput("osr_change_e111", 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(9);
        checkOutput("osr_pending_e120", 1'b1, 16'h7FFF, 1'b0);
        audio_rdy_i = 1'b1;
        applyStimulus(1);
        checkEq("osr_consumed_e121", 32'(audioValidO), 32'd0);
        pulses = 0;
        for (int i = 0; i < 375; i++) begin
            applyStimulus(1);
            if (audioValidO) pulses++;
        end
        checkEq("osr_quiet_windows", 32'(pulses), 32'd0);
        applyStimulus(1);
        checkOutput("osr_first_e497", 1'b1, 16'h7FFF, 1'b0);
        audio_rdy_i = 1'b0;
        applyStimulus(23);
        checkEq("rst_pre_valid", 32'(audioValidO), 32'd1);
        rst_i = 1'b1;
        applyStimulus(1);
        checkOutput("rst_mid", 1'b0, 16'h0000, 1'b0);
        rst_i  = 1'b0;
        patIdx = 0;
        applyStimulus(385);
        checkEq("rst_warm_e385", 32'(audioValidO), 32'd0);
        applyStimulus(1);
        checkOutput("rst_warm_e386", 1'b1, 16'h7FFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
